retry_rewind_start: RTL and testbench

- Transmitter-side retry stage with a go-back-N replay window, placed at the head of a protected pipeline.
- Tags each accepted upstream item with a wrapping ID and stores it in a circular replay buffer until the far end commits it.
- On a retry request carrying an ID, it rewinds the send pointer to that ID. It then re-emits that item and every later item in original order, followed by new items.

---
 rtl/retry_rewind_start.sv | 119 +++++++++++
 tb/tb_retry_rewind_start.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retry_rewind_start.sv
// Go-back-N retry stage: tags accepted items with wrapping IDs, holds them in a circular
// replay buffer until committed, and rewinds the send pointer on a retry request.
module retry_rewind_start #(
    parameter type         DataType = logic [7:0],
    parameter int unsigned IDSize   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  DataType           data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic [IDSize-1:0] retry_id_i,
    input  logic              retry_valid_i,
    output logic              retry_ready_o,
    input  logic [IDSize-1:0] commit_id_i,
    input  logic              commit_valid_i,
    output logic [IDSize:0]   count_o,
    output logic              err_o
);

    localparam int unsigned Depth = 1 << IDSize;

    typedef logic [IDSize:0]   ptr_t;
    typedef logic [IDSize-1:0] id_t;

    // Pointers carry an extra wrap bit so full (wr-cm == Depth) and empty (wr == cm) differ.
    ptr_t    wr_q, wr_d;
    ptr_t    rd_q, rd_d;
    ptr_t    cm_q, cm_d;
    logic    err_q, err_d;
    DataType mem_q [Depth];

    ptr_t occupancy;
    ptr_t in_flight;
    id_t  retry_dist;
    logic accept;
    logic send;
    logic commit_ok;
    logic retry_ok;

    always_comb begin
        occupancy  = wr_q - cm_q;
        in_flight  = rd_q - cm_q;
        retry_dist = retry_id_i - cm_q[IDSize-1:0];

        accept = valid_i & ready_o;
        send   = valid_o & ready_i;

        commit_ok = commit_valid_i && (cm_q != rd_q) && (commit_id_i == cm_q[IDSize-1:0]);
        // Window check uses the pre-commit cm; naming the entry retiring this cycle is illegal.
        retry_ok  = retry_valid_i && ({1'b0, retry_dist} < in_flight)
                    && !(commit_ok && (retry_dist == '0));
    end

    always_comb begin
        ready_o       = occupancy != ptr_t'(Depth);
        valid_o       = rd_q != wr_q;
        data_o        = mem_q[rd_q[IDSize-1:0]];
        id_o          = rd_q[IDSize-1:0];
        count_o       = occupancy;
        retry_ready_o = 1'b1;
        err_o         = err_q;
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cm_d  = cm_q;
        err_d = err_q;

        if (accept) begin
            wr_d = wr_q + ptr_t'(1);
        end

        // A legal retry wins over a same-cycle handshake; that item is simply resent.
        if (retry_ok) begin
            rd_d = cm_q + ptr_t'(retry_dist);
        end else if (send) begin
            rd_d = rd_q + ptr_t'(1);
        end

        if (commit_ok) begin
            cm_d = cm_q + ptr_t'(1);
        end

        if ((commit_valid_i && !commit_ok) || (retry_valid_i && !retry_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cm_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cm_q  <= cm_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_q[IDSize-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_retry_rewind_start.sv
// Directed bench for retry_rewind_start (IDSize=2): scoreboard queue of expected id/data
// pairs filled as items are pushed or replayed, drained by a negedge output monitor.
module tb_retry_rewind_start;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic [1:0] id_o;
    logic       valid_o;
    logic       ready_i;
    logic [1:0] retry_id_i;
    logic       retry_valid_i;
    logic       retry_ready_o;
    logic [1:0] commit_id_i;
    logic       commit_valid_i;
    logic [2:0] count_o;
    logic       err_o;

    int         vectors;
    int         miscompares;
    exp_t       q[$];
    logic [1:0] exp_id;

    retry_rewind_start #(
        .DataType(logic [7:0]),
        .IDSize  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .id_o          (id_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .retry_id_i    (retry_id_i),
        .retry_valid_i (retry_valid_i),
        .retry_ready_o (retry_ready_o),
        .commit_id_i   (commit_id_i),
        .commit_valid_i(commit_valid_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        check("push_ready", ready_o, 1);
        q.push_back({exp_id, d});
        exp_id  = exp_id + 2'd1;
        valid_i = 1'b1;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            tick();
        end
        check(tag, q.size(), 0);
    endtask

    task automatic apply_reset();
        rst_n          = 1'b1;
        valid_i        = 1'b0;
        retry_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        q.delete();
        exp_id = 2'd0;
        tick();
        rst_n = 1'b0;
    endtask

    // Handshakes under a same-cycle retry are discarded, so they are not consumed here.
    always @(negedge clk) begin
        if (valid_o && ready_i && !retry_valid_i) begin
            exp_t e;
            check("out_pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_id", id_o, e.id);
                check("out_data", data_o, e.data);
            end
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        exp_id         = 2'd0;
        rst_n          = 1'b1;
        data_i         = '0;
        valid_i        = 1'b0;
        ready_i        = 1'b1;
        retry_id_i     = '0;
        retry_valid_i  = 1'b0;
        commit_id_i    = '0;
        commit_valid_i = 1'b0;

        // Reset state
        #3;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_id", id_o, 0);
        check("rst_count", count_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_retry_ready", retry_ready_o, 1);
        tick();
        rst_n = 1'b0;

        // Fill to full; a push while full is refused
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("full_ready", ready_o, 0);
        check("full_count", count_o, 4);
        valid_i = 1'b1;
        data_i  = 8'hFF;
        tick();
        valid_i = 1'b0;
        check("full_hold_count", count_o, 4);
        wait_drain("drain_fill");
        check("fill_idle", valid_o, 0);

        // Commit frees a slot; next push wraps to id 0
        commit_valid_i = 1'b1;
        commit_id_i    = 2'd0;
        tick();
        commit_valid_i = 1'b0;
        check("commit_ready", ready_o, 1);
        check("commit_count", count_o, 3);
        check("commit_err", err_o, 0);
        push(8'hB0);
        wait_drain("drain_wrap");

        // Legal retry replays ids 1..3 in order
        apply_reset();
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        wait_drain("drain_pre_retry");
        q.push_back({2'd1, 8'hA1});
        q.push_back({2'd2, 8'hA2});
        q.push_back({2'd3, 8'hA3});
        retry_valid_i = 1'b1;
        retry_id_i    = 2'd1;
        tick();
        retry_valid_i = 1'b0;
        wait_drain("drain_replay");
        check("replay_idle", valid_o, 0);
        check("replay_err", err_o, 0);

        // Retry naming the entry committed this cycle: ignored, commit still lands
        retry_valid_i  = 1'b1;
        retry_id_i     = 2'd0;
        commit_valid_i = 1'b1;
        commit_id_i    = 2'd0;
        tick();
        retry_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        check("rc_err", err_o, 1);
        check("rc_count", count_o, 3);
        check("rc_valid", valid_o, 0);

        // Retry to an unsent id is illegal and sticky; stream continues with id 2
        apply_reset();
        push(8'hC0);
        push(8'hC1);
        wait_drain("drain_c");
        ready_i = 1'b0;
        push(8'hC2);
        retry_valid_i = 1'b1;
        retry_id_i    = 2'd3;
        tick();
        retry_valid_i = 1'b0;
        check("bad_retry_err", err_o, 1);
        check("bad_retry_id", id_o, 2);
        check("bad_retry_data", data_o, 8'hC2);
        ready_i = 1'b1;
        wait_drain("drain_c2");
        check("bad_retry_sticky", err_o, 1);

        // Retry overrides a same-cycle handshake on id 3
        apply_reset();
        push(8'hD0);
        push(8'hD1);
        push(8'hD2);
        wait_drain("drain_d");
        ready_i = 1'b0;
        push(8'hD3);
        check("pre_ovr_id", id_o, 3);
        q.delete();
        q.push_back({2'd2, 8'hD2});
        q.push_back({2'd3, 8'hD3});
        ready_i       = 1'b1;
        retry_valid_i = 1'b1;
        retry_id_i    = 2'd2;
        tick();
        retry_valid_i = 1'b0;
        check("ovr_id", id_o, 2);
        wait_drain("drain_ovr");
        check("ovr_err", err_o, 0);

        // Reset asserted mid-replay
        commit_valid_i = 1'b1;
        commit_id_i    = 2'd2;
        tick();
        commit_valid_i = 1'b0;
        check("bad_commit_err", err_o, 1);
        ready_i       = 1'b0;
        retry_valid_i = 1'b1;
        retry_id_i    = 2'd1;
        tick();
        retry_valid_i = 1'b0;
        check("mid_valid", valid_o, 1);
        check("mid_id", id_o, 1);
        rst_n = 1'b1;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_count", count_o, 0);
        check("arst_err", err_o, 0);
        check("arst_ready", ready_o, 1);
        q.delete();
        exp_id = 2'd0;
        tick();
        rst_n   = 1'b0;
        ready_i = 1'b1;
        push(8'hE0);
        wait_drain("drain_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
